// File: rtl/pc_redirect_pkg.sv
// Shared types and widths for the decode-stage PC redirect controller.
package pc_redirect_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } redir_state_e;

    // Sized for the largest legal MAX_WAIT (255) and FLUSH_CYCLES (7).
    localparam int WAIT_CNT_W  = 8;
    localparam int FLUSH_CNT_W = 3;
    localparam int STATS_W     = 16;

endpackage

// File: rtl/redir_sat_counter.sv
// Up-counter with synchronous clear and enable; saturates at MAX_VAL or wraps at full width.
module redir_sat_counter #(
    parameter int               WIDTH    = 8,
    parameter bit               SATURATE = 1'b1,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !(SATURATE && (count == MAX_VAL))) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Decode-stage PC redirect sequencer: operand wait, target handoff to fetch, F/D flush.
// Define REDIR_STATS_EN to build the taken/not-taken statistics counters.
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic              dec_is_cf,
    input  logic              jb_take,
    input  logic [ADDR_W-1:0] jb_target,
    input  logic              lag,
    input  logic              opnd_hazard,
    input  logic              fetch_ready,
    output logic              stall_fd,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_fd,
    output logic              wait_timeout,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       nottaken_cnt
);

    redir_state_e           state;
    logic                   cf;
    logic                   pend;
    logic                   wait_clr;
    logic                   wait_inc;
    logic                   wait_hit;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt;

    assign cf       = dec_valid & dec_is_cf;
    assign pend     = lag | opnd_hazard;
    assign wait_clr = (state == IDLE) & cf & pend;
    assign wait_inc = (state == WAIT) & pend;
    assign wait_hit = wait_inc & (wait_cnt == WAIT_CNT_W'(MAX_WAIT - 1));

    // Stall must assert in the same cycle the branch is seen in IDLE, so this path stays combinational.
    assign stall_fd = (state == WAIT) | (state == REDIRECT) |
                      ((state == IDLE) & cf & (pend | jb_take));

    redir_sat_counter #(
        .WIDTH    (WAIT_CNT_W),
        .SATURATE (1'b1),
        .MAX_VAL  (WAIT_CNT_W'(MAX_WAIT))
    ) u_wait_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (wait_clr),
        .enable (wait_inc),
        .count  (wait_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_fd       <= 1'b0;
            flush_cnt      <= '0;
            wait_timeout   <= 1'b0;
        end else begin
            if (wait_hit) begin
                wait_timeout <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cf && pend) begin
                        state <= WAIT;
                    end else if (cf && jb_take) begin
                        redirect_pc    <= jb_target;
                        redirect_valid <= 1'b1;
                        state          <= REDIRECT;
                    end
                end
                WAIT: begin
                    if (!pend && jb_take) begin
                        redirect_pc    <= jb_target;
                        redirect_valid <= 1'b1;
                        state          <= REDIRECT;
                    end else if (!pend) begin
                        state <= IDLE;
                    end
                end
                REDIRECT: begin
                    // Target is frozen here; jb_target may wander while fetch is busy.
                    if (fetch_ready) begin
                        redirect_valid <= 1'b0;
                        flush_fd       <= 1'b1;
                        flush_cnt      <= FLUSH_CNT_W'(FLUSH_CYCLES);
                        state          <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_CNT_W'(1)) begin
                        flush_fd <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REDIR_STATS_EN
    logic taken_inc;
    logic nottaken_inc;

    assign taken_inc    = (state == REDIRECT) & fetch_ready;
    assign nottaken_inc = ((state == IDLE) & cf & !pend & !jb_take) |
                          ((state == WAIT) & !pend & !jb_take);

    redir_sat_counter #(
        .WIDTH    (STATS_W),
        .SATURATE (1'b0),
        .MAX_VAL  ('1)
    ) u_taken_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (1'b0),
        .enable (taken_inc),
        .count  (taken_cnt)
    );

    redir_sat_counter #(
        .WIDTH    (STATS_W),
        .SATURATE (1'b0),
        .MAX_VAL  ('1)
    ) u_nottaken_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (1'b0),
        .enable (nottaken_inc),
        .count  (nottaken_cnt)
    );
`else
    assign taken_cnt    = '0;
    assign nottaken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomized bench for pc_redirect_ctrl; expected waveforms are derived per instruction
// from its pending length, taken flag and fetch back-pressure.
module tb_pc_redirect_ctrl;

    localparam int ADDR_W       = 32;
    localparam int FLUSH_CYCLES = 1;
    localparam int MAX_WAIT     = 15;

`ifdef REDIR_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              dec_valid;
    logic              dec_is_cf;
    logic              jb_take;
    logic [ADDR_W-1:0] jb_target;
    logic              lag;
    logic              opnd_hazard;
    logic              fetch_ready;
    logic              stall_fd;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_fd;
    logic              wait_timeout;
    logic [15:0]       taken_cnt;
    logic [15:0]       nottaken_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: statistic totals and the sticky timeout flag.
    int exp_taken    = 0;
    int exp_nottaken = 0;
    bit exp_sticky   = 1'b0;

    pc_redirect_ctrl #(
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MAX_WAIT     (MAX_WAIT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_is_cf      (dec_is_cf),
        .jb_take        (jb_take),
        .jb_target      (jb_target),
        .lag            (lag),
        .opnd_hazard    (opnd_hazard),
        .fetch_ready    (fetch_ready),
        .stall_fd       (stall_fd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_fd       (flush_fd),
        .wait_timeout   (wait_timeout),
        .taken_cnt      (taken_cnt),
        .nottaken_cnt   (nottaken_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic check_stats(input int taken_extra);
        check("taken_cnt", 32'(taken_cnt),
              STATS_ON ? 32'((exp_taken + taken_extra) & 16'hFFFF) : 32'd0);
        check("nottaken_cnt", 32'(nottaken_cnt), STATS_ON ? 32'(exp_nottaken & 16'hFFFF) : 32'd0);
    endtask

    // One cycle with no control-flow instruction in decode.
    task automatic run_idle();
        int r;
        r = $urandom_range(0, 2);
        dec_valid   = r[0];
        dec_is_cf   = r[1];
        jb_take     = 1'($urandom);
        jb_target   = $urandom;
        lag         = 1'($urandom);
        opnd_hazard = 1'($urandom);
        fetch_ready = 1'($urandom);
        @(negedge clock);
        check("idle stall_fd", 32'(stall_fd), 32'd0);
        check("idle redirect_valid", 32'(redirect_valid), 32'd0);
        check("idle flush_fd", 32'(flush_fd), 32'd0);
        check("idle wait_timeout", 32'(wait_timeout), 32'(exp_sticky));
        check_stats(0);
        @(posedge clock);
        #1;
    endtask

    // One control-flow instruction: operands pending for p cycles (including the IDLE cycle),
    // then resolved with 'take'; fetch holds ready low for d cycles of the redirect.
    // src selects the pending source: 0 random mix, 1 lag only, 2 opnd_hazard only.
    task automatic run_insn(input int p, input bit take, input logic [31:0] target,
                            input int d, input int src);
        int last;
        int r;
        int wmin;
        bit in_redir;
        bit exp_stall;
        bit exp_to;
        last = take ? p + 1 + d + FLUSH_CYCLES : p;
        for (int c = 0; c <= last; c++) begin
            in_redir    = take && (c > p) && (c <= p + 1 + d);
            dec_valid   = (c == 0) ? 1'b1 : 1'($urandom);
            dec_is_cf   = (c == 0) ? 1'b1 : 1'($urandom);
            if (c < p) begin
                r = (src == 1) ? 1 : (src == 2) ? 2 : int'($urandom_range(1, 3));
                lag         = r[0];
                opnd_hazard = r[1];
            end else if (c == p) begin
                lag         = 1'b0;
                opnd_hazard = 1'b0;
            end else begin
                lag         = 1'($urandom);
                opnd_hazard = 1'($urandom);
            end
            jb_take     = (c == p) ? take : 1'($urandom);
            jb_target   = (c == p) ? target : $urandom;
            fetch_ready = in_redir ? (c == p + 1 + d) : 1'($urandom);
            @(negedge clock);
            exp_stall = (c < p) || ((c == p) && (p > 0 || take)) || in_redir;
            wmin      = (c < p) ? c : p;
            exp_to    = exp_sticky || (p > 0 && (wmin - 1) >= MAX_WAIT);
            check("stall_fd", 32'(stall_fd), 32'(exp_stall));
            check("redirect_valid", 32'(redirect_valid), 32'(in_redir));
            check("flush_fd", 32'(flush_fd), 32'(take && (c > p + 1 + d)));
            check("wait_timeout", 32'(wait_timeout), 32'(exp_to));
            if (in_redir) check("redirect_pc", redirect_pc, target);
            check_stats((take && c > p + 1 + d) ? 1 : 0);
            @(posedge clock);
            #1;
        end
        if (take) exp_taken++;
        else      exp_nottaken++;
        if (p > 0 && (p - 1) >= MAX_WAIT) exp_sticky = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall_fd"}, 32'(stall_fd), 32'd0);
        check({tag, " redirect_valid"}, 32'(redirect_valid), 32'd0);
        check({tag, " redirect_pc"}, redirect_pc, 32'd0);
        check({tag, " flush_fd"}, 32'(flush_fd), 32'd0);
        check({tag, " wait_timeout"}, 32'(wait_timeout), 32'd0);
        check({tag, " taken_cnt"}, 32'(taken_cnt), 32'd0);
        check({tag, " nottaken_cnt"}, 32'(nottaken_cnt), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        dec_valid   = 1'b0;
        dec_is_cf   = 1'b0;
        jb_take     = 1'b0;
        jb_target   = '0;
        lag         = 1'b0;
        opnd_hazard = 1'b0;
        fetch_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed scenarios.
        run_insn(0, 1'b0, 32'h0, 0, 0);            // not-taken bne, zero penalty
        run_insn(0, 1'b1, 32'h0000_0040, 0, 0);    // taken j, immediate accept
        run_idle();
        run_insn(4, 1'b1, 32'h0000_0100, 0, 1);    // blt behind a multicycle op
        run_insn(0, 1'b1, 32'h0000_0abc, 3, 0);    // fetch back-pressure, target wandering
        run_insn(20, 1'b1, 32'h0000_0200, 1, 2);   // long hazard trips the timeout
        run_insn(2, 1'b0, 32'h0, 0, 0);            // timeout stays sticky
        run_idle();

        // Reset while a redirect is waiting for fetch.
        dec_valid   = 1'b1;
        dec_is_cf   = 1'b1;
        lag         = 1'b0;
        opnd_hazard = 1'b0;
        jb_take     = 1'b1;
        jb_target   = 32'hdead_bee0;
        fetch_ready = 1'b0;
        @(posedge clock);
        #1;
        dec_valid = 1'b0;
        #2;
        check("pre-reset redirect_valid", 32'(redirect_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clock);
        reset = 1'b1;
        exp_taken    = 0;
        exp_nottaken = 0;
        exp_sticky   = 1'b0;
        @(posedge clock);
        #1;
        run_idle();
        run_insn(1, 1'b1, 32'h0000_1234, 0, 0);

        // Random instruction stream.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                run_idle();
            end else begin
                run_insn(($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                                     : int'($urandom_range(0, 4)),
                         1'($urandom), $urandom, int'($urandom_range(0, 3)), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
